// File: rtl/perf_counter_bank_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_pkg;

   // Bank sequencing: count, stream the counts out, then park.
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      DUMP = 2'd1,
      DONE = 2'd2
   } perfState_t;

   // Default channel assignment for the core's event strobes.
   localparam int EVT_RETIRE = 0;
   localparam int EVT_ICREQ  = 1;
   localparam int EVT_ICHIT  = 2;
   localparam int EVT_DCREQ  = 3;
   localparam int EVT_DCHIT  = 4;
   localparam int EVT_CYCLE  = 5;

   // Index width that stays at least one bit for a single-channel bank.
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Dump stream port: valid/ready beats carrying one channel count each.
interface perf_counter_bank_if #(
   parameter int NUM_EVT = 6,
   parameter int CNT_W   = 32
) ();
   localparam int IW = perf_pkg::idxWidth(NUM_EVT);

   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_idx;
   logic [CNT_W-1:0] out_data;
   logic          out_last;

   modport master (
      output out_valid, out_idx, out_data, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_idx, out_data, out_last,
      output out_ready
   );
endinterface

// File: rtl/perf_counter_bank_counter.sv
// One event channel: counter with wrap or saturate and a sticky overflow flag.
module perf_counter #(
   parameter int CNT_W    = 32,
   parameter int SAT_MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   // clr wins over a same-cycle increment; overflow latches until clr/rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (inc) begin
         if (&cnt) begin
            ovf <= 1'b1;
            cnt <= (SAT_MODE != 0) ? cnt : '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/perf_counter_bank.sv
// Event counter bank: counts core strobes, freezes on halt, streams counts out.
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int NUM_EVT  = 6,
   parameter int CNT_W    = 32,
   parameter int SAT_MODE = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   input  logic [NUM_EVT-1:0]                evt,
   input  logic                              halt,
   input  logic                              clr,
   input  logic [idxWidth(NUM_EVT)-1:0]      rd_sel,
   output logic [CNT_W-1:0]                  rd_data,
   output logic [NUM_EVT-1:0]                ovf,
   output logic                              frozen,
   output logic                              done,
   perf_counter_bank_if.master               dumpIf
);

   localparam int IW = idxWidth(NUM_EVT);
   localparam logic [IW-1:0] LAST = IW'(NUM_EVT - 1);

   perfState_t                       state;
   logic [IW-1:0]                    idx;
   logic                             validR;
   logic                             doneR;
   logic                             frozenR;
   logic [NUM_EVT-1:0]               inc;
   logic [NUM_EVT-1:0][CNT_W-1:0]    cntArr;
   logic [CNT_W-1:0]                 outData;

   // Counting only happens in RUN; a halting cycle still counts its events.
   assign inc = (state == RUN && en) ? evt : '0;

   genvar g;
   generate
      for (g = 0; g < NUM_EVT; g++) begin : gChan
         perf_counter #(
            .CNT_W    (CNT_W),
            .SAT_MODE (SAT_MODE)
         ) uCnt (
            .clk (clk),
            .rst (rst),
            .inc (inc[g]),
            .clr (clr),
            .cnt (cntArr[g]),
            .ovf (ovf[g])
         );
      end
   endgenerate

   // FSM with registered stream/status flags; clr overrides halt and handshakes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RUN;
         idx     <= '0;
         validR  <= 1'b0;
         doneR   <= 1'b0;
         frozenR <= 1'b0;
      end else if (clr) begin
         state   <= RUN;
         idx     <= '0;
         validR  <= 1'b0;
         doneR   <= 1'b0;
         frozenR <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (halt) begin
                  state   <= DUMP;
                  idx     <= '0;
                  validR  <= 1'b1;
                  frozenR <= 1'b1;
               end
            end
            DUMP: begin
               if (dumpIf.out_ready) begin
                  if (idx == LAST) begin
                     state  <= DONE;
                     validR <= 1'b0;
                     doneR  <= 1'b1;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            DONE: ;
            default: begin
               state   <= RUN;
               idx     <= '0;
               validR  <= 1'b0;
               doneR   <= 1'b0;
               frozenR <= 1'b0;
            end
         endcase
      end
   end

   // Random-access read; selects beyond the last channel read as zero.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_EVT; i++) begin
         if (rd_sel == IW'(i)) rd_data = cntArr[i];
      end
   end

   // Dump beat payload for the current index.
   always_comb begin
      outData = '0;
      for (int i = 0; i < NUM_EVT; i++) begin
         if (idx == IW'(i)) outData = cntArr[i];
      end
   end

   assign dumpIf.out_valid = validR;
   assign dumpIf.out_idx   = idx;
   assign dumpIf.out_data  = outData;
   assign dumpIf.out_last  = validR && (idx == LAST);
   assign frozen           = frozenR;
   assign done             = doneR;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: 32-bit wrap bank plus 8-bit wrap and saturate banks.
module tb_perf_counter_bank;
   import perf_pkg::*;

   typedef struct {
      int          idx;
      logic [63:0] data;
      bit          last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [5:0]  evt = '0;
   logic        halt = 1'b0;
   logic        clr = 1'b0;
   logic [2:0]  rdSel = '0;
   logic        outReady = 1'b0;

   logic [31:0] rd0;
   logic [7:0]  rd1, rd2;
   logic [5:0]  ovf0, ovf1, ovf2;
   logic        frozen0, frozen1, frozen2;
   logic        done0, done1, done2;

   int total = 0;
   int bad = 0;
   beat_t sbq[$];
   longint mdl[6];
   bit mdlRun = 1'b1;

   perf_counter_bank_if #(.NUM_EVT(6), .CNT_W(32)) if0 ();
   perf_counter_bank_if #(.NUM_EVT(6), .CNT_W(8))  if1 ();
   perf_counter_bank_if #(.NUM_EVT(6), .CNT_W(8))  if2 ();
   assign if0.out_ready = outReady;
   assign if1.out_ready = outReady;
   assign if2.out_ready = outReady;

   perf_counter_bank #(.NUM_EVT(6), .CNT_W(32), .SAT_MODE(0)) u0 (
      .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .clr(clr),
      .rd_sel(rdSel), .rd_data(rd0), .ovf(ovf0), .frozen(frozen0),
      .done(done0), .dumpIf(if0));
   perf_counter_bank #(.NUM_EVT(6), .CNT_W(8), .SAT_MODE(0)) u1 (
      .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .clr(clr),
      .rd_sel(rdSel), .rd_data(rd1), .ovf(ovf1), .frozen(frozen1),
      .done(done1), .dumpIf(if1));
   perf_counter_bank #(.NUM_EVT(6), .CNT_W(8), .SAT_MODE(1)) u2 (
      .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .clr(clr),
      .rd_sel(rdSel), .rd_data(rd2), .ovf(ovf2), .frozen(frozen2),
      .done(done2), .dumpIf(if2));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock with the given strobes; the model tracks the 32-bit bank.
   task automatic tick(input logic [5:0] e, input logic h, input logic c);
      evt = e; halt = h; clr = c;
      @(posedge clk); #1;
      if (c) begin
         foreach (mdl[i]) mdl[i] = 0;
         mdlRun = 1'b1;
      end else if (mdlRun) begin
         if (en) for (int i = 0; i < 6; i++) if (e[i]) mdl[i]++;
         if (h) mdlRun = 1'b0;
      end
      evt = '0; halt = 1'b0; clr = 1'b0;
   endtask

   task automatic pushAll();
      for (int i = 0; i < 6; i++) sbq.push_back('{idx: i, data: mdl[i], last: (i == 5)});
   endtask

   // Drain the dump, popping expected beats on each transfer.
   task automatic runDump(input bit toggle, input int expCycles);
      int c;
      bit holdV;
      logic [2:0]  hIdx;
      logic [31:0] hData;
      beat_t b;
      holdV = 1'b0;
      hIdx = '0;
      hData = '0;
      for (c = 0; c < 64 && sbq.size() > 0; c++) begin
         if (holdV) begin
            chk("holdIdx", 64'(if0.out_idx), 64'(hIdx));
            chk("holdData", 64'(if0.out_data), 64'(hData));
            holdV = 1'b0;
         end
         outReady = toggle ? (c % 2 == 0) : 1'b1;
         chk("dumpValid", 64'(if0.out_valid), 64'd1);
         if (outReady) begin
            b = sbq.pop_front();
            chk("beatIdx", 64'(if0.out_idx), 64'(b.idx));
            chk("beatData", 64'(if0.out_data), b.data);
            chk("beatLast", 64'(if0.out_last), 64'(b.last));
         end else begin
            holdV = 1'b1;
            hIdx = if0.out_idx;
            hData = if0.out_data;
         end
         @(posedge clk); #1;
      end
      outReady = 1'b0;
      chk("dumpLeft", 64'(sbq.size()), 64'd0);
      chk("dumpCycles", 64'(c), 64'(expCycles));
      chk("doneAfter", 64'(done0), 64'd1);
      chk("validAfter", 64'(if0.out_valid), 64'd0);
   endtask

   initial begin
      foreach (mdl[i]) mdl[i] = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      chk("rstValid", 64'(if0.out_valid), 64'd0);
      chk("rstDone", 64'(done0), 64'd0);
      chk("rstFrozen", 64'(frozen0), 64'd0);
      chk("rstOvf", 64'(ovf0), 64'd0);
      chk("rstCnt", 64'(rd0), 64'd0);

      // Channels 0 and 1 for ten cycles, then halt.
      en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(6'b000011, 1'b0, 1'b0);
         if (i == 0) chk("latency", 64'(rd0), 64'd1);
      end
      rdSel = 3'd1;
      #1 chk("rdSel1", 64'(rd0), 64'd10);
      rdSel = 3'd6;
      #1 chk("rdSelOob", 64'(rd0), 64'd0);
      rdSel = 3'd0;
      tick(6'b000000, 1'b1, 1'b0);
      chk("haltFrozen", 64'(frozen0), 64'd1);
      chk("haltValid", 64'(if0.out_valid), 64'd1);
      pushAll();
      runDump(1'b0, 6);
      tick(6'b000001, 1'b1, 1'b0);
      chk("doneHoldsHalt", 64'(done0), 64'd1);
      chk("doneNoCount", 64'(rd0), 64'd10);

      // clr beats a simultaneous evt.
      tick(6'b000001, 1'b0, 1'b1);
      chk("clrState", 64'(frozen0), 64'd0);
      chk("clrDone", 64'(done0), 64'd0);
      chk("clrBeatsEvt", 64'(rd0), 64'd0);

      // halt with evt in the same cycle, toggled ready during dump.
      repeat (4) tick(6'b000001, 1'b0, 1'b0);
      tick(6'b000001, 1'b1, 1'b0);
      pushAll();
      chk("haltSameCycle", 64'(if0.out_data), 64'd5);
      runDump(1'b1, 11);

      // clr during beat 2.
      tick(6'b000000, 1'b0, 1'b1);
      repeat (3) tick(6'b111111, 1'b0, 1'b0);
      tick(6'b000000, 1'b1, 1'b0);
      outReady = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      outReady = 1'b0;
      chk("midIdx", 64'(if0.out_idx), 64'd2);
      tick(6'b000000, 1'b1, 1'b1);
      rdSel = 3'd2;
      #1;
      chk("midClrValid", 64'(if0.out_valid), 64'd0);
      chk("midClrFrozen", 64'(frozen0), 64'd0);
      chk("midClrCnt", 64'(rd0), 64'd0);
      rdSel = 3'd0;
      repeat (2) tick(6'b100100, 1'b0, 1'b0);
      tick(6'b000000, 1'b1, 1'b0);
      pushAll();
      runDump(1'b0, 6);

      // Overflow on the 8-bit banks.
      tick(6'b000000, 1'b0, 1'b1);
      repeat (257) tick(6'b000001, 1'b0, 1'b0);
      chk("wrapCnt", 64'(rd1), 64'd1);
      chk("wrapOvf", 64'(ovf1), 64'd1);
      chk("satCnt", 64'(rd2), 64'd255);
      chk("satOvf", 64'(ovf2), 64'd1);
      chk("wideCnt", 64'(rd0), 64'd257);
      chk("wideOvf", 64'(ovf0), 64'd0);

      // Asynchronous reset mid-dump.
      tick(6'b000000, 1'b1, 1'b0);
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      chk("preRstValid", 64'(if0.out_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("asyncValid", 64'(if0.out_valid), 64'd0);
      chk("asyncCnt", 64'(rd0), 64'd0);
      chk("asyncOvf", 64'(ovf1), 64'd0);
      chk("asyncFrozen", 64'(frozen0), 64'd0);
      #1 rst = 1'b0;
      foreach (mdl[i]) mdl[i] = 0;
      mdlRun = 1'b1;
      @(posedge clk); #1;

      // en low blocks counting.
      en = 1'b0;
      repeat (5) tick(6'b111111, 1'b0, 1'b0);
      chk("enLow", 64'(rd0), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Synthesizable, parametrised event-counter bank that replaces bench-only instruction and cache hit/request tallies with in-design hardware counters. Each channel counts a one-bit event strobe from the processor (retire, I/D-cache request, I/D-cache hit, and similar). Counting freezes when halt is seen. The bank then streams every count out over a valid/ready port, so the simulation log or an on-chip debug path can collect the statistics. It sits beside the processor core and samples core strobes only; it never back-pressures the core.

## Interface
- NUM_EVT, 6, number of event channels (1..16)
- CNT_W, 32, counter width in bits (8..64)
- SAT_MODE, 0, 0 = wrap on overflow, 1 = saturate at all-ones
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  global count enable
- evt  in  NUM_EVT  per-channel event strobes; one increment per cycle when high
- halt  in  1  processor halted strobe
- clr  in  1  synchronous clear; zeroes counters and overflow flags, returns to RUN
- rd_sel  in  $clog2(NUM_EVT)  random-access read select
- rd_data  out  CNT_W  count of channel rd_sel; combinational; 0 if rd_sel >= NUM_EVT
- ovf  out  NUM_EVT  sticky per-channel overflow flags
- frozen  out  1  high in DUMP and DONE
- out_valid  out  1  dump stream valid
- out_ready  in  1  dump stream ready
- out_idx  out  $clog2(NUM_EVT)  channel index of current dump beat
- out_data  out  CNT_W  count of channel out_idx
- out_last  out  1  high on the beat for channel NUM_EVT-1
- done  out  1  high in DONE

## Operation
- FSM states: RUN, DUMP, DONE. Reset state is RUN.
- Reset values: all counters 0, ovf 0, idx 0, out_valid 0, done 0, frozen 0.
- RUN:
  - Channel i increments when en && evt[i].
  - When halt is high, that cycle's events are still counted; next state is DUMP with idx = 0.
- DUMP:
  - No counting.
  - out_valid = 1, out_idx = idx, out_data = counter[idx], out_last = (idx == NUM_EVT-1).
  - A beat transfers on out_valid && out_ready; idx then increments.
  - A transfer with out_last goes to DONE.
  - out_* hold stable while out_ready is low.
- DONE:
  - No counting; out_valid = 0; done = 1.
  - Holds until clr or rst.
- halt in DUMP or DONE is ignored.
- clr in any state, including mid-dump:
  - Zeroes counters, ovf and idx; next state is RUN.
  - clr beats a simultaneous evt: the counter becomes 0, not 1.
  - clr beats a simultaneous halt: the state becomes RUN.
- Overflow, on an increment from all-ones:
  - SAT_MODE = 0: counter becomes 0 and ovf[i] is set.
  - SAT_MODE = 1: counter holds all-ones and ovf[i] is set.
  - ovf bits clear only on clr or rst.
- rd_sel reads are valid in every state and have no side effects.

## Timing
- An evt high at posedge N is visible on rd_data after posedge N (one-cycle latency).
- halt at posedge N: frozen and out_valid are high after N, first beat is channel 0.
- Dump with out_ready held high takes NUM_EVT cycles; done rises one cycle after the last-beat transfer.
- rst asserted mid-dump clears everything immediately (asynchronously); out_valid drops without a handshake.

## Structure
- Package perf_pkg: FSM state enum (RUN/DUMP/DONE) and the default channel index constants (EVT_RETIRE = 0, EVT_ICREQ, EVT_ICHIT, EVT_DCREQ, EVT_DCHIT, EVT_CYCLE).
- Sub-module perf_counter, instantiated once per channel, parameters CNT_W and SAT_MODE:
  - inputs: inc, clr
  - outputs: cnt, ovf
- perf_counter_bank holds the FSM, index counter and output muxes.

## Test plan
- Reset, then evt = 6'b000011 for 10 cycles, then halt:
  - dump beats read 10, 10, 0, 0, 0, 0
  - out_last on idx 5; done = 1 afterward
- halt and evt[0] in the same cycle after 4 prior evt[0] → channel 0 dumps 5.
- CNT_W = 8, SAT_MODE = 0: 257 increments → count 1, ovf[0] = 1. With SAT_MODE = 1 → count 255, ovf[0] = 1.
- out_ready toggling 1010… during dump:
  - each beat held stable until it transfers
  - exactly 6 transfers with idx 0..5 in order
- clr during beat idx 2 → state RUN, all counts 0, out_valid 0 next cycle; a new count-and-halt sequence dumps fresh values.
- rst pulse mid-dump between clock edges → out_valid, counters and ovf drop to 0 immediately; en low for 5 cycles of evt → no increments.
